coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage between the two raw coin-slot sensors and the vending machine controller.
- Synchronises and debounces the sensors, classifies each coin, and drives the controller's coin[1:0] bus with a single-cycle code per accepted coin.
- Pulses a reject gate for invalid insertions: both sensors at once, or a coin arriving while the controller is not ready.
- Enforces release and inter-coin gap so that one physical coin produces exactly one code.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles needed to qualify a coin, and consecutive low cycles needed to qualify release. Legal range is 2 to 2**CNT_W-1.
- GAP_CYCLES, 3: idle cycles enforced after release before a new coin is considered. Legal range is 1 to 2**CNT_W-1.
- CNT_W, 8: width of the shared debounce/gap counter.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- sense_a, input, 1: raw, asynchronous sensor for the 1-unit coin.
- sense_b, input, 1: raw, asynchronous sensor for the 2-unit coin.
- enable, input, 1: controller ready to accept a coin. Level, sampled by the acceptor.
- coin, output, 2: coin code to the controller. 2'b01 = 1 unit, 2'b10 = 2 units, 2'b00 = none. 2'b11 is never driven.
- reject, output, 1: one-cycle pulse to the reject gate.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-low.
  - While rst_n is low at a rising edge: both 2-FF synchronisers, the counter, the latched pattern and the state are cleared. At that edge coin=2'b00, reject=0, busy=0.
  - Reset applied mid-operation aborts any coin in flight with no coin or reject pulse.
- Inputs and outputs:
  - Each sensor passes through a 2-FF synchroniser. Synchronised values are sa and sb.
  - All outputs are registered.
- State IDLE:
  - If {sb,sa} != 0: go to QUAL, set cnt=1, latch pat={sb,sa}.
- State QUAL:
  - If {sb,sa} == 0: the event is a glitch. Go to IDLE, no output.
  - Otherwise: pat |= {sb,sa} (any overlap makes pat=2'b11) and cnt increments.
  - When cnt == DEBOUNCE_CYCLES, sample enable and go to DECIDE.
- State DECIDE, one cycle:
  - pat is 01 or 10 and enable was 1: coin=pat for exactly this cycle.
  - Otherwise (pat == 11, or enable was 0): reject=1 for exactly this cycle. coin stays 00.
  - Then go to HOLD with cnt=0.
- State HOLD:
  - Count consecutive cycles with {sb,sa} == 0. Any high sample resets cnt to 0.
  - A new press during HOLD is treated as the same coin and never emits.
  - At cnt == DEBOUNCE_CYCLES go to GAP with cnt=0.
- State GAP:
  - Wait GAP_CYCLES cycles, ignoring the sensors, then go to IDLE.
  - A sensor still high on the return to IDLE starts a new qualification.
- Latency:
  - coin or reject asserts at the (DEBOUNCE_CYCLES+2)th rising edge after the edge that first samples the raw sensor high.
  - It is high for exactly one cycle.
- Enable rule:
  - enable is sampled only at the QUAL-to-DECIDE edge.
  - Changes to enable at any other time have no effect.
- Ordering:
  - At most one coin/reject pulse per physical insertion.
  - Minimum spacing between pulses is 2*DEBOUNCE_CYCLES+GAP_CYCLES+1 cycles.
- Counter:
  - cnt is unsigned CNT_W bits and never wraps; parameter legality guarantees this.
- Illegal input:
  - Sensors asserted during reset: ignored until the first post-reset synchroniser sample.

Optional Feature:
- Macro: COIN_TALLY_EN.
- When defined, adds three outputs:
  - tally_a [7:0]: increments on each coin=01 pulse.
  - tally_b [7:0]: increments on each coin=10 pulse.
  - tally_rej [7:0]: increments on each reject pulse.
- All three saturate at 8'hFF, are cleared by reset, and update on the same edge the pulse is registered.
- When not defined, these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Defaults, enable=1, sense_a high 20 cycles: coin=2'b01 for one cycle at edge 6 after first sample. No reject. busy falls 4+3 cycles after the synchronised release.
- sense_b high 3 cycles then low: no coin, no reject. busy returns to 0 the cycle after the synchronised drop.
- sense_a and sense_b overlapping by 1 cycle within qualification: reject=1 for one cycle, coin stays 2'b00.
- enable=0 during a sense_b insertion, with enable returning to 1 before release: reject=1, coin stays 2'b00. A second sense_b insertion after the gap gives coin=2'b10.
- sense_a bouncing (low 2 cycles) during HOLD, then a clean release: exactly one coin=2'b01 pulse in total.
- rst_n low for 1 cycle during QUAL of sense_a: no pulse, busy=0 after the edge. Sensor held high afterwards qualifies again, giving coin=2'b01 at edge 6 after reset release. With COIN_TALLY_EN defined, tallies read 0 after reset and tally_a=1 after this coin.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: front end between the two raw coin-slot sensors and the vending controller.
// Latency: coin/reject is registered on the (DEBOUNCE_CYCLES+2)th rising edge after the first raw-high sample.
// Backpressure: enable is sampled once, when qualification completes; a coin arriving while the controller
//   is not ready is rejected. Extra presses before release and gap are absorbed silently.
// Ports: clk, rst_n (sync, active-low), sense_a/sense_b (raw async sensors), enable (controller ready),
//   coin[1:0] (01 = 1 unit, 10 = 2 units), reject (one-cycle gate pulse), busy (state not IDLE).
// Optional: define COIN_TALLY_EN to add saturating 8-bit tallies tally_a, tally_b and tally_rej.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 3,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sense_a,
   input  logic       sense_b,
   input  logic       enable,
   output logic [1:0] coin,
   output logic       reject,
   output logic       busy
`ifdef COIN_TALLY_EN
   ,
   output logic [7:0] tally_a,
   output logic [7:0] tally_b,
   output logic [7:0] tally_rej
`endif
);

   localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_QUAL   = 3'd1,
      S_DECIDE = 3'd2,
      S_HOLD   = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   state_t           state_q;
   logic [1:0]       sync_a_q;
   logic [1:0]       sync_b_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       pat_q;
   logic [1:0]       coin_q;
   logic             reject_q;
   logic             busy_q;

   logic [1:0]       sens;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       pat_d;
   logic             qual_done;
   logic             accept;
   logic             refuse;

   // Synchronised sensor pair; bit 0 is the 1-unit sensor.
   assign sens    = {sync_b_q[1], sync_a_q[1]};
   assign cnt_inc = cnt_q + 1'b1;
   assign pat_d   = pat_q | sens;

   // The decision is taken on the edge that completes qualification so that the
   // registered pulse is visible during the single DECIDE cycle.
   assign qual_done = (state_q == S_QUAL) && (sens != 2'b00) && (cnt_inc == DEB_LIM);
   assign accept    = qual_done && enable && (pat_d != 2'b11);
   assign refuse    = qual_done && !accept;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a_q <= 2'b00;
         sync_b_q <= 2'b00;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pat_q    <= 2'b00;
         coin_q   <= 2'b00;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync_a_q <= {sync_a_q[0], sense_a};
         sync_b_q <= {sync_b_q[0], sense_b};
         coin_q   <= 2'b00;
         reject_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sens != 2'b00) begin
                  state_q <= S_QUAL;
                  cnt_q   <= CNT_W'(1);
                  pat_q   <= sens;
                  busy_q  <= 1'b1;
               end
            end
            S_QUAL: begin
               if (sens == 2'b00) begin
                  // Released before qualifying: treat as a glitch.
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  pat_q <= pat_d;
                  cnt_q <= cnt_inc;
                  if (qual_done) begin
                     state_q <= S_DECIDE;
                     if (accept) coin_q <= pat_d;
                     if (refuse) reject_q <= 1'b1;
                  end
               end
            end
            S_DECIDE: begin
               state_q <= S_HOLD;
               cnt_q   <= '0;
            end
            S_HOLD: begin
               // Release must be seen low for a full debounce window; any bounce restarts it.
               if (sens != 2'b00) begin
                  cnt_q <= '0;
               end else if (cnt_inc == DEB_LIM) begin
                  state_q <= S_GAP;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            S_GAP: begin
               if (cnt_inc == GAP_LIM) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign coin   = coin_q;
   assign reject = reject_q;
   assign busy   = busy_q;

`ifdef COIN_TALLY_EN
   logic [7:0] tally_a_q;
   logic [7:0] tally_b_q;
   logic [7:0] tally_rej_q;

   // Tallies move on the same edge that registers the pulse, saturating at 8'hFF.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tally_a_q   <= 8'h00;
         tally_b_q   <= 8'h00;
         tally_rej_q <= 8'h00;
      end else begin
         if (accept && (pat_d == 2'b01) && (tally_a_q != 8'hFF)) tally_a_q <= tally_a_q + 8'h01;
         if (accept && (pat_d == 2'b10) && (tally_b_q != 8'hFF)) tally_b_q <= tally_b_q + 8'h01;
         if (refuse && (tally_rej_q != 8'hFF)) tally_rej_q <= tally_rej_q + 8'h01;
      end
   end

   assign tally_a   = tally_a_q;
   assign tally_b   = tally_b_q;
   assign tally_rej = tally_rej_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed bench for coin_acceptor with default parameters.
// Drives inputs 1 time unit after each rising edge and samples outputs at the same point.
// Pulse counters accumulate every cycle so that stray or duplicate pulses are caught per scenario.
module tb_coin_acceptor;

   logic       clk;
   logic       rst_n;
   logic       sense_a;
   logic       sense_b;
   logic       enable;
   logic [1:0] coin;
   logic       reject;
   logic       busy;
`ifdef COIN_TALLY_EN
   logic [7:0] tally_a;
   logic [7:0] tally_b;
   logic [7:0] tally_rej;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_a      = 0;
   int n_b      = 0;
   int n_rej    = 0;
   int n_bad    = 0;

   coin_acceptor dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sense_a (sense_a),
      .sense_b (sense_b),
      .enable  (enable),
      .coin    (coin),
      .reject  (reject),
      .busy    (busy)
`ifdef COIN_TALLY_EN
      ,
      .tally_a   (tally_a),
      .tally_b   (tally_b),
      .tally_rej (tally_rej)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle and tally any pulse present this cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (coin == 2'b01) n_a++;
      if (coin == 2'b10) n_b++;
      if (coin == 2'b11) n_bad++;
      if (reject) n_rej++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_counts();
      n_a   = 0;
      n_b   = 0;
      n_rej = 0;
      n_bad = 0;
   endtask

   // Bounded wait for the acceptor to return to IDLE, plus a few quiet cycles.
   task automatic wait_idle(input string tag);
      int budget;
      budget = 40;
      while (busy && budget > 0) begin
         step();
         budget--;
      end
      check(tag, int'(busy), 0);
      steps(3);
   endtask

   initial begin
      rst_n   = 1'b0;
      sense_a = 1'b0;
      sense_b = 1'b0;
      enable  = 1'b1;

      // Reset state.
      steps(3);
      check("rst_coin", int'(coin), 0);
      check("rst_reject", int'(reject), 0);
      check("rst_busy", int'(busy), 0);
`ifdef COIN_TALLY_EN
      check("rst_tally_a", int'(tally_a), 0);
      check("rst_tally_rej", int'(tally_rej), 0);
`endif
      rst_n = 1'b1;
      steps(3);

      // 1: clean 1-unit coin, sensor high for 20 edges.
      clear_counts();
      sense_a = 1'b1;
      steps(5);
      check("t1_coin_e5", int'(coin), 0);
      step();
      check("t1_coin_e6", int'(coin), 1);
      check("t1_busy_e6", int'(busy), 1);
      step();
      check("t1_coin_e7", int'(coin), 0);
      steps(13);
      sense_a = 1'b0;
      steps(8);
      check("t1_busy_rel8", int'(busy), 1);
      step();
      check("t1_busy_rel9", int'(busy), 0);
      steps(3);
      check("t1_n_a", n_a, 1);
      check("t1_n_rej", n_rej, 0);

      // 2: 3-cycle glitch on sense_b.
      clear_counts();
      sense_b = 1'b1;
      steps(3);
      sense_b = 1'b0;
      steps(2);
      check("t2_busy_e5", int'(busy), 1);
      step();
      check("t2_busy_e6", int'(busy), 0);
      steps(6);
      check("t2_n_b", n_b, 0);
      check("t2_n_rej", n_rej, 0);

      // 3: both sensors overlapping for one cycle inside qualification.
      clear_counts();
      sense_a = 1'b1;
      step();
      sense_b = 1'b1;
      step();
      sense_a = 1'b0;
      steps(3);
      check("t3_rej_e5", int'(reject), 0);
      step();
      check("t3_rej_e6", int'(reject), 1);
      check("t3_coin_e6", int'(coin), 0);
      step();
      check("t3_rej_e7", int'(reject), 0);
      steps(4);
      sense_b = 1'b0;
      wait_idle("t3_idle");
      check("t3_n_rej", n_rej, 1);
      check("t3_n_coin", n_a + n_b, 0);

      // 4: controller not ready at the decision edge, ready again before release.
      clear_counts();
      enable  = 1'b0;
      sense_b = 1'b1;
      steps(6);
      check("t4_rej_e6", int'(reject), 1);
      check("t4_coin_e6", int'(coin), 0);
      enable = 1'b1;
      steps(5);
      sense_b = 1'b0;
      wait_idle("t4_idle1");
      check("t4_n_rej", n_rej, 1);
      check("t4_n_b0", n_b, 0);
      sense_b = 1'b1;
      steps(6);
      check("t4_coin2_e6", int'(coin), 2);
      steps(4);
      sense_b = 1'b0;
      wait_idle("t4_idle2");
      check("t4_n_b1", n_b, 1);
      check("t4_n_rej_end", n_rej, 1);

      // 5: sense_a bounces low for 2 cycles during HOLD.
      clear_counts();
      sense_a = 1'b1;
      steps(10);
      sense_a = 1'b0;
      steps(2);
      sense_a = 1'b1;
      steps(5);
      sense_a = 1'b0;
      wait_idle("t5_idle");
      check("t5_n_a", n_a, 1);
      check("t5_n_rej", n_rej, 0);

      // 6: reset during qualification, sensor held through and after reset.
      clear_counts();
      sense_a = 1'b1;
      steps(4);
      check("t6_busy_qual", int'(busy), 1);
      rst_n = 1'b0;
      step();
      check("t6_busy_rst", int'(busy), 0);
      check("t6_coin_rst", int'(coin), 0);
`ifdef COIN_TALLY_EN
      check("t6_tally_a_rst", int'(tally_a), 0);
      check("t6_tally_b_rst", int'(tally_b), 0);
`endif
      rst_n = 1'b1;
      steps(5);
      check("t6_coin_e5", int'(coin), 0);
      step();
      check("t6_coin_e6", int'(coin), 1);
`ifdef COIN_TALLY_EN
      check("t6_tally_a", int'(tally_a), 1);
`endif
      steps(3);
      sense_a = 1'b0;
      wait_idle("t6_idle");
      check("t6_n_a", n_a, 1);
      check("t6_n_rej", n_rej, 0);
      check("all_no_11", n_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
